// File: rtl/pe_cfg_pkg.sv
// Shared types and field widths for the PE configuration sequencer and FU config bus.
package pe_cfg_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Field widths of one FU configuration word, MSB field first.
  localparam int CONFIG_CMAC   = 16;
  localparam int CONFIG_CORDIC = 8;
  localparam int CONFIG_LOGI   = 9;
  localparam int CONFIG_DMEM   = 31;
  localparam int CONFIG_ALL_W  = CONFIG_CMAC + CONFIG_CORDIC + CONFIG_LOGI + CONFIG_DMEM;

  // Packed view of the FU config bus: {cmac, cordic, logical, dmem}.
  typedef struct packed {
    logic [CONFIG_CMAC-1:0]   cmac;
    logic [CONFIG_CORDIC-1:0] cordic;
    logic [CONFIG_LOGI-1:0]   logi;
    logic [CONFIG_DMEM-1:0]   dmem;
  } cfg_word_t;

endpackage

// File: rtl/pe_cfg_mem.sv
// Program store: DEPTH entries of {repeat count, config word}, one write port and
// one combinational read port. Contents are not reset.
module pe_cfg_mem #(
  parameter int CONFIG_ALL = 64,
  parameter int DEPTH      = 16,
  parameter int REP_W      = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [CONFIG_ALL-1:0]    wdata,
  input  logic [REP_W-1:0]         wrep,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [CONFIG_ALL-1:0]    rdata,
  output logic [REP_W-1:0]         rrep
);

  localparam int EW = CONFIG_ALL + REP_W;

  logic [EW-1:0] mem_reg [DEPTH];

  // Single write port; a same-cycle read of the written entry still sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= {wrep, wdata};
    end
  end

  assign rdata = mem_reg[raddr][CONFIG_ALL-1:0];
  assign rrep  = mem_reg[raddr][EW-1:CONFIG_ALL];

endmodule

// File: rtl/pe_config_seq.sv
// Replays a start..end range of program words onto the FU config bus, holding each
// word rep+1 cycles and looping the range a programmable number of times.
module pe_config_seq
  import pe_cfg_pkg::*;
#(
  parameter int CONFIG_ALL = 64,
  parameter int DEPTH      = 16,
  parameter int REP_W      = 4,
  parameter int LOOP_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_waddr,
  input  logic [CONFIG_ALL-1:0]    cfg_wdata,
  input  logic [REP_W-1:0]         cfg_wrep,
  input  logic                     start,
  input  logic [$clog2(DEPTH)-1:0] start_addr,
  input  logic [$clog2(DEPTH)-1:0] end_addr,
  input  logic [LOOP_W-1:0]        loop_cnt,
  input  logic                     stall,
  output logic [CONFIG_ALL-1:0]    config_all,
  output logic                     config_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);

  seq_state_t             state_reg, state_next;
  logic [AW-1:0]          pc_reg, pc_next;
  logic [AW-1:0]          start_reg, start_next;
  logic [AW-1:0]          end_reg, end_next;
  logic [REP_W-1:0]       rep_cnt_reg, rep_cnt_next;
  logic [LOOP_W-1:0]      loop_reg, loop_next;
  logic [CONFIG_ALL-1:0]  config_reg, config_next;
  logic                   valid_reg, valid_next;
  logic                   done_reg, done_next;
  logic                   err_reg, err_next;
  logic                   mem_we;
  logic [CONFIG_ALL-1:0]  rd_word;
  logic [REP_W-1:0]       rd_rep;

  pe_cfg_mem #(
    .CONFIG_ALL (CONFIG_ALL),
    .DEPTH      (DEPTH),
    .REP_W      (REP_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cfg_waddr),
    .wdata (cfg_wdata),
    .wrep  (cfg_wrep),
    .raddr (pc_reg),
    .rdata (rd_word),
    .rrep  (rd_rep)
  );

  // State, counters and registered outputs; reset clears outputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      start_reg   <= '0;
      end_reg     <= '0;
      rep_cnt_reg <= '0;
      loop_reg    <= '0;
      config_reg  <= '0;
      valid_reg   <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      start_reg   <= start_next;
      end_reg     <= end_next;
      rep_cnt_reg <= rep_cnt_next;
      loop_reg    <= loop_next;
      config_reg  <= config_next;
      valid_reg   <= valid_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  // Next-state, counter stepping and program-write gating.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    start_next   = start_reg;
    end_next     = end_reg;
    rep_cnt_next = rep_cnt_reg;
    loop_next    = loop_reg;
    config_next  = config_reg;
    valid_next   = valid_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    mem_we       = 1'b0;

    case (state_reg)
      IDLE: begin
        mem_we = cfg_we;
        if (start) begin
          if (start_addr <= end_addr) begin
            start_next   = start_addr;
            end_next     = end_addr;
            pc_next      = start_addr;
            rep_cnt_next = '0;
            loop_next    = (loop_cnt == '0) ? LOOP_W'(1) : loop_cnt;
            state_next   = RUN;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      RUN: begin
        // Program writes are refused while replaying; starts are silently ignored.
        err_next = cfg_we;
        if (!stall) begin
          config_next = rd_word;
          valid_next  = 1'b1;
          if (rep_cnt_reg < rd_rep) begin
            rep_cnt_next = rep_cnt_reg + REP_W'(1);
          end else begin
            rep_cnt_next = '0;
            if (pc_reg == end_reg) begin
              // Explicit reload keeps a full-depth range from relying on pc overflow.
              if (loop_reg > LOOP_W'(1)) begin
                pc_next   = start_reg;
                loop_next = loop_reg - LOOP_W'(1);
              end else begin
                state_next = DONE;
              end
            end else begin
              pc_next = pc_reg + AW'(1);
            end
          end
        end
      end

      DONE: begin
        mem_we      = cfg_we;
        config_next = '0;
        valid_next  = 1'b0;
        done_next   = 1'b1;
        state_next  = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign config_all   = config_reg;
  assign config_valid = valid_reg;
  assign busy         = (state_reg == RUN);
  assign done         = done_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_pe_config_seq.sv
// Scoreboard bench: runs push the expected word stream, a negedge monitor pops and
// compares every freshly presented word and checks held words during stalls.
module tb_pe_config_seq;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_waddr;
  logic [63:0] cfg_wdata;
  logic [3:0]  cfg_wrep;
  logic        start;
  logic [3:0]  start_addr;
  logic [3:0]  end_addr;
  logic [7:0]  loop_cnt;
  logic        stall;
  logic [63:0] config_all;
  logic        config_valid;
  logic        busy;
  logic        done;
  logic        err;

  pe_config_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_waddr    (cfg_waddr),
    .cfg_wdata    (cfg_wdata),
    .cfg_wrep     (cfg_wrep),
    .start        (start),
    .start_addr   (start_addr),
    .end_addr     (end_addr),
    .loop_cnt     (loop_cnt),
    .stall        (stall),
    .config_all   (config_all),
    .config_valid (config_valid),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int exp_err = 0;
  int err_seen = 0;
  int exp_done = 0;
  int done_seen = 0;

  // Reference program image and expected word stream.
  logic [63:0] model_data [16];
  int          model_rep  [16];
  logic [63:0] exp_q [$];

  logic        stall_at_edge = 1'b0;
  logic [63:0] last_exp = '0;
  bit          have_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stall value the DUT saw at the most recent rising edge.
  initial forever begin
    @(posedge clk);
    stall_at_edge = stall;
  end

  // Monitor: each valid sample following a non-stalled edge is a new word.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      have_last = 1'b0;
    end else begin
      if (config_valid) begin
        if (stall_at_edge && have_last) begin
          check("stall_hold", config_all, last_exp);
        end else if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h expected none", config_all);
        end else begin
          last_exp = exp_q.pop_front();
          have_last = 1'b1;
          check("word", config_all, last_exp);
        end
      end else begin
        have_last = 1'b0;
      end
      if (done) begin
        done_seen++;
        check("done_nop", config_all, 64'd0);
        check("done_valid", {63'd0, config_valid}, 64'd0);
        check("done_q_empty", 64'(exp_q.size()), 64'd0);
      end
      if (err) err_seen++;
    end
  end

  task automatic write_entry(input int addr, input logic [63:0] data, input int rep);
    cfg_we = 1'b1;
    cfg_waddr = 4'(addr);
    cfg_wdata = data;
    cfg_wrep = 4'(rep);
    tick();
    cfg_we = 1'b0;
    model_data[addr] = data;
    model_rep[addr] = rep;
  endtask

  task automatic bad_start(input int sa, input int ea);
    start = 1'b1;
    start_addr = 4'(sa);
    end_addr = 4'(ea);
    loop_cnt = 8'd1;
    tick();
    start = 1'b0;
    exp_err++;
    check("bad_start_err", {63'd0, err}, 64'd1);
    check("bad_start_busy", {63'd0, busy}, 64'd0);
    check("bad_start_valid", {63'd0, config_valid}, 64'd0);
    tick();
  endtask

  // Launch a range; optional forced 2-cycle stall, refused write, or mid-run reset.
  task automatic run(input int sa, input int ea, input int lc, input int pct,
                     input int stall_at, input int bad_we_at, input int rst_at);
    int eff;
    int cyc;
    bit fin;
    eff = (lc == 0) ? 1 : lc;
    for (int l = 0; l < eff; l++)
      for (int a = sa; a <= ea; a++)
        for (int r = 0; r <= model_rep[a]; r++)
          exp_q.push_back(model_data[a]);
    start = 1'b1;
    start_addr = 4'(sa);
    end_addr = 4'(ea);
    loop_cnt = 8'(lc);
    tick();
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    cyc = 0;
    fin = 1'b0;
    while (!fin) begin
      stall = (cyc == stall_at) || (cyc == stall_at + 1) || ($urandom_range(0, 99) < pct);
      if (cyc == bad_we_at) begin
        cfg_we = 1'b1;
        cfg_waddr = 4'($urandom_range(0, 15));
        cfg_wdata = {$urandom, $urandom};
        cfg_wrep = 4'($urandom_range(0, 15));
      end
      tick();
      cfg_we = 1'b0;
      if (cyc == bad_we_at) begin
        exp_err++;
        check("busy_write_err", {63'd0, err}, 64'd1);
      end
      if (cyc == rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_config", config_all, 64'd0);
        check("rst_valid", {63'd0, config_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        exp_q.delete();
        stall = 1'b0;
        tick();
        rst_n = 1'b1;
        fin = 1'b1;
      end else if (done) begin
        exp_done++;
        fin = 1'b1;
      end else if (cyc > 3000) begin
        tests++;
        fails++;
        $display("FAIL run_timeout: got no done expected done within 3000 cycles");
        fin = 1'b1;
      end
      cyc++;
    end
    stall = 1'b0;
    tick();
  endtask

  initial begin
    int sa;
    int ea;
    int kind;
    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_waddr = '0;
    cfg_wdata = '0;
    cfg_wrep = '0;
    start = 1'b0;
    start_addr = '0;
    end_addr = '0;
    loop_cnt = '0;
    stall = 1'b0;
    tick();
    tick();
    check("reset_config", config_all, 64'd0);
    check("reset_valid", {63'd0, config_valid}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_err", {63'd0, err}, 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) write_entry(i, {$urandom, $urandom}, 0);

    // Simple four-word range.
    for (int i = 0; i < 4; i++) write_entry(i, 64'hA0 + 64'(i), 0);
    run(0, 3, 1, 0, -10, -10, -10);
    // Single entry with repeat 3, looped twice: 8 cycles of one word.
    write_entry(2, 64'hA2, 3);
    run(2, 2, 2, 0, -10, -10, -10);
    // Two-cycle stall in the middle of the second word.
    write_entry(2, 64'hA2, 0);
    run(1, 2, 3, 0, 2, -10, -10);
    // Rejected start.
    bad_start(5, 3);
    // Refused write while busy, then rerun of the original program.
    run(0, 3, 2, 0, -10, 0, -10);
    run(0, 3, 1, 0, -10, -10, -10);
    // Reset mid-run, then a normal run.
    run(0, 3, 3, 0, -10, -10, 3);
    run(0, 3, 1, 0, -10, -10, -10);
    // Loop count 0 behaves as 1; full-depth range wraps by reload.
    run(0, 1, 0, 0, -10, -10, -10);
    for (int i = 0; i < 16; i++) write_entry(i, {$urandom, $urandom}, $urandom_range(0, 2));
    run(0, 15, 2, 20, -10, -10, -10);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        write_entry($urandom_range(0, 15), {$urandom, $urandom}, $urandom_range(0, 3));
      end else if (kind == 2) begin
        ea = $urandom_range(0, 14);
        sa = $urandom_range(ea + 1, 15);
        bad_start(sa, ea);
      end else begin
        sa = $urandom_range(0, 15);
        ea = $urandom_range(sa, 15);
        run(sa, ea, $urandom_range(0, 3), 25, -10,
            ($urandom_range(0, 6) == 0) ? 0 : -10, -10);
      end
    end

    tick();
    check("err_count", 64'(err_seen), 64'(exp_err));
    check("done_count", 64'(done_seen), 64'(exp_done));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
